// File: rtl/seg_to_bin_decoder.sv
// Rebuilds a binary magnitude and sign from a digit-serial seven-segment bus, flagging illegal patterns.
// Optional SEG_ACTIVE_LOW_EN: treat seg_in as a common-anode (active-low) bus.
module seg_to_bin_decoder #(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned OUT_W      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             sign_in,
    input  logic [6:0]       seg_in,
    input  logic             digit_strobe,
    output logic [OUT_W-1:0] value_out,
    output logic             sign_out,
    output logic             out_valid,
    output logic             out_err
);

    localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int unsigned DIG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               fsign_q, fsign_d;
    logic [OUT_W-1:0]   value_q, value_d;
    logic               sign_out_q, sign_out_d;
    logic               out_valid_q, out_valid_d;
    logic               out_err_q, out_err_d;

    logic [6:0]         seg_c;
    logic [DIG_W-1:0]   digit_c;
    logic               digit_ok_c;

    // Normalise bus polarity so the decode table is always active-high.
`ifdef SEG_ACTIVE_LOW_EN
    assign seg_c = ~seg_in;
`else
    assign seg_c = seg_in;
`endif

    // Pattern to digit; anything outside the table decodes as 0 and is flagged.
    always_comb begin
        digit_c    = '0;
        digit_ok_c = 1'b1;
        case (seg_c)
            7'h7E:   digit_c = DIG_W'(0);
            7'h30:   digit_c = DIG_W'(1);
            7'h6D:   digit_c = DIG_W'(2);
            7'h79:   digit_c = DIG_W'(3);
            7'h33:   digit_c = DIG_W'(4);
            7'h5B:   digit_c = DIG_W'(5);
            7'h5F:   digit_c = DIG_W'(6);
            7'h70:   digit_c = DIG_W'(7);
            7'h7F:   digit_c = DIG_W'(8);
            7'h7B:   digit_c = DIG_W'(9);
            7'h00:   digit_c = DIG_W'(0);
            default: digit_ok_c = 1'b0;
        endcase
    end

    logic               open_c;
    logic [OUT_W-1:0]   acc_base_c;
    logic [CNT_W-1:0]   cnt_base_c;
    logic               err_base_c;
    logic               fsign_base_c;
    logic [OUT_W-1:0]   acc_step_c;
    logic [CNT_W-1:0]   cnt_step_c;
    logic               err_step_c;

    // Next state: frame_start wins over everything and may carry the first digit.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fsign_d      = fsign_q;
        value_d      = value_q;
        sign_out_d   = sign_out_q;
        out_err_d    = out_err_q;
        out_valid_d  = 1'b0;

        open_c       = frame_start || (state_q == ST_COLLECT);
        acc_base_c   = frame_start ? '0 : acc_q;
        cnt_base_c   = frame_start ? '0 : cnt_q;
        err_base_c   = frame_start ? 1'b0 : err_q;
        fsign_base_c = frame_start ? sign_in : fsign_q;

        acc_step_c   = (acc_base_c << 3) + (acc_base_c << 1) + OUT_W'(digit_c);
        cnt_step_c   = cnt_base_c + CNT_W'(1);
        err_step_c   = err_base_c | ~digit_ok_c;

        if (frame_start) begin
            state_d = ST_COLLECT;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            fsign_d = sign_in;
        end else begin
            case (state_q)
                ST_DONE:    state_d = ST_IDLE;
                ST_COLLECT: state_d = ST_COLLECT;
                default:    state_d = ST_IDLE;
            endcase
        end

        if (open_c && digit_strobe) begin
            if (cnt_step_c == CNT_W'(NUM_DIGITS)) begin
                // Final digit: results are registered now so out_valid lines up with DONE.
                state_d     = ST_DONE;
                acc_d       = '0;
                cnt_d       = '0;
                err_d       = 1'b0;
                value_d     = err_step_c ? '0 : acc_step_c;
                sign_out_d  = fsign_base_c;
                out_err_d   = err_step_c;
                out_valid_d = 1'b1;
            end else begin
                acc_d = acc_step_c;
                cnt_d = cnt_step_c;
                err_d = err_step_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            fsign_q     <= 1'b0;
            value_q     <= '0;
            sign_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fsign_q     <= fsign_d;
            value_q     <= value_d;
            sign_out_q  <= sign_out_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign value_out = value_q;
    assign sign_out  = sign_out_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_seg_to_bin_decoder.sv
// Scoreboard bench for seg_to_bin_decoder: directed frames plus randomized frames, aborts and stray strobes.
module tb_seg_to_bin_decoder;

    localparam int unsigned ND = 2;
    localparam int unsigned OW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          sign_in;
    logic [6:0]    seg_in;
    logic          digit_strobe;
    logic [OW-1:0] value_out;
    logic          sign_out;
    logic          out_valid;
    logic          out_err;

    seg_to_bin_decoder #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .sign_in      (sign_in),
        .seg_in       (seg_in),
        .digit_strobe (digit_strobe),
        .value_out    (value_out),
        .sign_out     (sign_out),
        .out_valid    (out_valid),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     val;
        bit     sg;
        bit     err;
        longint cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Display glyphs for 0..9, then blank (which also means 0).
    logic [6:0] tbl [11] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                             7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h00};

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic void ref_decode(input logic [6:0] p, output int d, output bit ok);
        d  = 0;
        ok = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (tbl[i] == p) begin
                ok = 1'b1;
                d  = (i == 10) ? 0 : i;
            end
        end
    endfunction

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(0, 99) < 85) return tbl[$urandom_range(0, 10)];
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic drive(input logic fs, input logic sg, input logic st, input logic [6:0] pat);
        @(negedge clk);
        frame_start  = fs;
        sign_in      = sg;
        digit_strobe = st;
        seg_in       = enc(pat);
    endtask

    task automatic idle(input int n, input bit stray);
        repeat (n) drive(1'b0, 1'($urandom_range(0, 1)), stray, 7'($urandom_range(0, 127)));
    endtask

    // Full frame; expectation is pushed alongside the final strobe.
    task automatic send_frame(input logic sg, input logic [6:0] pats [ND], input bit merge,
                              input int max_gap);
        int   total;
        bit   err;
        int   d;
        bit   ok;
        exp_t e;
        total = 0;
        err   = 1'b0;
        for (int i = 0; i < ND; i++) begin
            ref_decode(pats[i], d, ok);
            total = total * 10 + d;
            if (!ok) err = 1'b1;
        end
        if (!merge) drive(1'b1, sg, 1'b0, 7'($urandom_range(0, 127)));
        for (int i = 0; i < ND; i++) begin
            if (merge && i == 0) begin
                drive(1'b1, sg, 1'b1, pats[0]);
            end else begin
                idle($urandom_range(0, max_gap), 1'b0);
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, pats[i]);
            end
        end
        e.val = err ? 0 : (total % (1 << OW));
        e.sg  = sg;
        e.err = err;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    // Opens a frame and supplies k < ND digits; the next frame_start must abort it.
    task automatic send_partial(input logic sg, input logic [6:0] pats [ND], input int k);
        drive(1'b1, sg, 1'b0, 7'($urandom_range(0, 127)));
        for (int i = 0; i < k; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, pats[i]);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " value_out"}, value_out, 0);
        check({tag, " sign_out"}, sign_out, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_err"}, out_err, 0);
    endtask

    // Monitor: pops on every out_valid and checks that outputs hold between reports.
    int  held_val = 0;
    bit  held_sg  = 1'b0;
    bit  held_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            held_val = 0;
            held_sg  = 1'b0;
            held_err = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("value_out", value_out, e.val);
                check("sign_out", sign_out, e.sg);
                check("out_err", out_err, e.err);
                check("latency cycle", cyc, e.cyc);
                held_val = e.val;
                held_sg  = e.sg;
                held_err = e.err;
            end
        end else begin
            check("held outputs", {value_out, sign_out, out_err},
                  {OW'(held_val), held_sg, held_err});
        end
    end

    initial begin
        logic [6:0] p [ND];
        reset        = 1'b1;
        frame_start  = 1'b0;
        sign_in      = 1'b0;
        digit_strobe = 1'b0;
        seg_in       = 7'h00;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        #1 reset = 1'b0;

        p = '{7'h30, 7'h7B};
        send_frame(1'b0, p, 1'b0, 0);
        idle(3, 1'b1);
        p = '{7'h00, 7'h7F};
        send_frame(1'b1, p, 1'b0, 1);
        idle(2, 1'b0);
        p = '{7'h6D, 7'h0F};
        send_frame(1'b0, p, 1'b0, 0);
        idle(2, 1'b0);
        p = '{7'h79, 7'h00};
        send_partial(1'b0, p, 1);
        p = '{7'h33, 7'h5B};
        send_frame(1'b0, p, 1'b1, 0);
        p = '{7'h00, 7'h7E};
        send_frame(1'b1, p, 1'b0, 0);
        p = '{7'h30, 7'h7E};
        send_frame(1'b0, p, 1'b0, 0);
        idle(3, 1'b0);

        // Reset in the middle of a frame after a nonzero report.
        drive(1'b1, 1'b1, 1'b0, 7'h00);
        drive(1'b0, 1'b0, 1'b1, 7'h79);
        @(negedge clk);
        digit_strobe = 1'b0;
        frame_start  = 1'b0;
        #1 reset = 1'b1;
        #1 check_zero_outputs("async reset");
        @(negedge clk);
        #1 reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 7'h30);
        idle(4, 1'b0);
        check_zero_outputs("after reset");

        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < ND; i++) p[i] = rand_pat();
            if ($urandom_range(0, 4) == 0) send_partial(1'($urandom_range(0, 1)), p, $urandom_range(1, ND - 1));
            for (int i = 0; i < ND; i++) p[i] = rand_pat();
            send_frame(1'($urandom_range(0, 1)), p, 1'($urandom_range(0, 1)), 2);
            idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        idle(2, 1'b0);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/seg_to_bin_decoder.md
# seg_to_bin_decoder

Receive-side counterpart of the binary-to-display converter: it watches a digit-serial seven-segment bus (segment pattern, minus sign, digit strobe), decodes each pattern back to a decimal digit and rebuilds the binary value. It sits on the checking side of the arithmetic exercise blocks and turns their display output back into a number that can be compared with the arithmetic result. Invalid segment patterns are flagged rather than silently mapped.

## Interface
- NUM_DIGITS, 2, digits per frame, most significant first; legal range 1..4
- OUT_W, 7, width of the recovered magnitude; must hold 10^NUM_DIGITS−1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse that opens a frame; clears the accumulator and samples sign_in
- sign_in  in  1  minus indicator, 1 = negative
- seg_in  in  7  segment pattern, bit6 = a … bit0 = g, active-high
- digit_strobe  in  1  one-cycle pulse; seg_in holds a valid digit this cycle
- value_out  out  OUT_W  recovered magnitude, held until the next frame completes
- sign_out  out  1  sign sampled at frame_start, held with value_out
- out_valid  out  1  one-cycle pulse when a frame completes
- out_err  out  1  set with out_valid if any digit in the frame was invalid; held with value_out

## Operation
- Decode table (hex, bit6..0): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 00 (blank)→0. Every other pattern is invalid; it contributes digit 0 and sets the frame error flag.
- FSM states:
  - IDLE: digit_strobe ignored; frame_start → COLLECT.
  - COLLECT: each strobe updates acc = acc·10 + digit, implemented as (acc<<3)+(acc<<1)+digit and truncated to OUT_W bits, and increments the digit counter. When the strobe making count = NUM_DIGITS is taken → DONE.
  - DONE: one cycle. Register value_out (or 0 if the frame error flag is set), sign_out and out_err, pulse out_valid, then → IDLE.
- frame_start arriving in COLLECT or DONE aborts the open frame (no out_valid for it), clears acc, counter and error flag, resamples sign_in, and stays in or enters COLLECT.
- frame_start and digit_strobe in the same cycle: the frame opens and that strobe is taken as the first digit.
- Negative zero is passed through unchanged (sign_out = 1, value_out = 0).

## Timing
- Reset values: value_out = 0, sign_out = 0, out_valid = 0, out_err = 0, state IDLE, acc = 0, counter = 0.
- A strobe is sampled at the rising edge where digit_strobe = 1.
- out_valid is high for exactly the one cycle after the edge that samples the final strobe. Latency is 1 cycle from the last strobe.
- Minimum spacing is one strobe per cycle. Back-to-back frames are legal: frame_start may coincide with the DONE cycle, and the completed frame still reports.
- Reset asserted mid-frame returns all state to the reset values immediately and discards the partial frame.
- value_out, sign_out and out_err change only in the DONE cycle.

## Configuration
- SEG_ACTIVE_LOW_EN defined: seg_in is inverted before decoding (common-anode bus), so bit patterns are the complements of the table, e.g. 0x01 → 0 and 0x7F → blank.
- SEG_ACTIVE_LOW_EN undefined: seg_in is decoded active-high exactly as tabled.

## Test plan
- Reset, then frame_start with sign_in = 0, strobes 30, 7B → out_valid once, one cycle after the second strobe, with value_out = 19, sign_out = 0, out_err = 0.
- frame_start with sign_in = 1, strobes 00, 7F → value_out = 8, sign_out = 1, out_err = 0.
- Strobes 6D, 0F (invalid) → out_err = 1, value_out = 0.
- frame_start, strobe 79, then frame_start together with strobe 33, then strobe 5B → the aborted frame gives no out_valid; the completed frame reports value_out = 45.
- Strobe 79, then reset pulse, then strobe 30 with no frame_start → all outputs stay 0 and no out_valid.
- With SEG_ACTIVE_LOW_EN defined, strobes 0x4F, 0x01 → value_out = 10.
